// File: rtl/text_console_writer_pkg.sv
// Shared constants and types for the character-cell text console.
// The FSM either accepts characters (StIdle) or sweeps spaces over the screen or one line.
package text_console_writer_pkg;

  localparam logic [7:0] AsciiSpace = 8'h20;
  localparam logic [7:0] AsciiLf    = 8'h0A;
  localparam logic [7:0] AsciiCr    = 8'h0D;
  localparam logic [7:0] AsciiBs    = 8'h08;

  typedef enum logic [1:0] {
    StIdle,
    StClrAll,
    StClrLine
  } txt_state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Producer-side character port: valid/ready transfer, clear request and busy status.
interface text_console_writer_if;

  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_char;
  logic       clr_req;
  logic       busy;

  modport master (
    output wr_valid,
    output wr_char,
    output clr_req,
    input  wr_ready,
    input  busy
  );

  modport slave (
    input  wr_valid,
    input  wr_char,
    input  clr_req,
    output wr_ready,
    output busy
  );

endinterface

// File: rtl/text_console_writer_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module text_console_writer_ram #(
  parameter int unsigned Depth = 4800,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [Depth];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/text_console_writer.sv
// Text console: cursor-tracking character writer with line/screen clear, plus a
// one-cycle pixel-to-cell read path feeding the glyph renderer.
module text_console_writer
  import text_console_writer_pkg::*;
#(
  parameter int unsigned Cols  = 80,
  parameter int unsigned Rows  = 60,
  parameter int unsigned CharW = 8,
  parameter int unsigned CharH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  text_console_writer_if.slave      wr_if,
  output logic [$clog2(Cols)-1:0]   cursor_col_o,
  output logic [$clog2(Rows)-1:0]   cursor_row_o,
  input  logic [9:0]                x_i,
  input  logic [9:0]                y_i,
  output logic [7:0]                rd_char_o,
  output logic [$clog2(CharW)-1:0]  rd_cell_x_o,
  output logic [$clog2(CharH)-1:0]  rd_cell_y_o,
  output logic                      rd_active_o
);

  localparam int unsigned ColW  = $clog2(Cols);
  localparam int unsigned RowW  = $clog2(Rows);
  localparam int unsigned Cells = Cols * Rows;
  localparam int unsigned AddrW = $clog2(Cells);
  localparam int unsigned XOffW = $clog2(CharW);
  localparam int unsigned YOffW = $clog2(CharH);

  localparam logic [AddrW-1:0] ColsA    = AddrW'(Cols);
  localparam logic [AddrW-1:0] LastCell = AddrW'(Cells - 1);
  localparam logic [AddrW-1:0] LastLine = AddrW'(Cols - 1);
  localparam logic [ColW-1:0]  LastCol  = ColW'(Cols - 1);
  localparam logic [RowW-1:0]  LastRow  = RowW'(Rows - 1);

  function automatic logic [AddrW-1:0] cell_addr(input logic [ColW-1:0] c,
                                                 input logic [RowW-1:0] r);
    return AddrW'(r) * ColsA + AddrW'(c);
  endfunction

  txt_state_t       state_q, state_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [AddrW-1:0] cnt_q, cnt_d;
  logic             we;
  logic [AddrW-1:0] waddr;
  logic [7:0]       wdata;
  logic             ready;
  logic             busy;
  logic             adv_row;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    waddr   = cell_addr(col_q, row_q);
    wdata   = AsciiSpace;
    ready   = 1'b0;
    busy    = 1'b0;
    adv_row = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A clear request pre-empts any char offered in the same cycle.
        ready = ~wr_if.clr_req;
        if (wr_if.clr_req) begin
          state_d = StClrAll;
          cnt_d   = '0;
        end else if (wr_if.wr_valid) begin
          if (is_printable(wr_if.wr_char)) begin
            we    = 1'b1;
            wdata = wr_if.wr_char;
            if (col_q == LastCol) begin
              col_d   = '0;
              adv_row = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else if (wr_if.wr_char == AsciiLf) begin
            col_d   = '0;
            adv_row = 1'b1;
          end else if (wr_if.wr_char == AsciiCr) begin
            col_d = '0;
          end else if (wr_if.wr_char == AsciiBs && col_q != '0) begin
            col_d = col_q - 1'b1;
            we    = 1'b1;
            waddr = cell_addr(col_q - 1'b1, row_q);
          end
        end
        if (adv_row) begin
          if (row_q == LastRow) begin
            row_d   = '0;
            state_d = StClrLine;
            cnt_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      StClrAll: begin
        busy  = 1'b1;
        we    = 1'b1;
        waddr = cnt_q;
        if (cnt_q == LastCell) begin
          state_d = StIdle;
          col_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StClrLine: begin
        if (wr_if.clr_req) begin
          state_d = StClrAll;
          cnt_d   = '0;
        end else begin
          we    = 1'b1;
          waddr = cell_addr(cnt_q[ColW-1:0], row_q);
          if (cnt_q == LastLine) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StClrAll;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StClrAll;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr_if.wr_ready = ready;
  assign wr_if.busy     = busy;
  assign cursor_col_o   = col_q;
  assign cursor_row_o   = row_q;

  // Read side: pixel to cell address, then one register stage for data and offsets.
  logic [9:0]       rd_col, rd_row;
  logic             rd_in_grid;
  logic [AddrW-1:0] rd_addr;
  logic [7:0]       ram_rdata;
  logic             active_q;
  logic [XOffW-1:0] cell_x_q;
  logic [YOffW-1:0] cell_y_q;

  assign rd_col     = x_i >> XOffW;
  assign rd_row     = y_i >> YOffW;
  assign rd_in_grid = (rd_col < 10'(Cols)) && (rd_row < 10'(Rows));
  assign rd_addr    = rd_in_grid ? cell_addr(rd_col[ColW-1:0], rd_row[RowW-1:0]) : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      cell_x_q <= '0;
      cell_y_q <= '0;
    end else begin
      active_q <= rd_in_grid;
      cell_x_q <= x_i[XOffW-1:0];
      cell_y_q <= y_i[YOffW-1:0];
    end
  end

  text_console_writer_ram #(
    .Depth (Cells),
    .AddrW (AddrW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  assign rd_char_o   = active_q ? ram_rdata : AsciiSpace;
  assign rd_cell_x_o = cell_x_q;
  assign rd_cell_y_o = cell_y_q;
  assign rd_active_o = active_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: screen/cursor model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_text_console_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  logic [7:0] rd_char;
  logic [2:0] rd_cell_x;
  logic [2:0] rd_cell_y;
  logic       rd_active;

  int n_cmp = 0;
  int n_err = 0;

  text_console_writer_if wr_if ();

  text_console_writer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wr_if        (wr_if),
    .cursor_col_o (cursor_col),
    .cursor_row_o (cursor_row),
    .x_i          (x),
    .y_i          (y),
    .rd_char_o    (rd_char),
    .rd_cell_x_o  (rd_cell_x),
    .rd_cell_y_o  (rd_cell_y),
    .rd_active_o  (rd_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] scr [4800];
  int  mcol = 0, mrow = 0;
  int  clear_left = 0;     // edges remaining until the block accepts chars again
  bit  kind_all = 1'b1;    // current clear covers the whole screen
  bit  started = 1'b0;
  bit  rd_ok = 1'b0;
  logic [7:0] exp_char = 8'h20;
  logic       exp_act = 1'b0;
  logic [2:0] exp_cx = '0, exp_cy = '0;

  function automatic void next_row();
    if (mrow == 59) begin
      mrow = 0;
      clear_left = 80;
      kind_all = 1'b0;
    end else begin
      mrow++;
    end
  endfunction

  function automatic void apply_char(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      scr[mrow * 80 + mcol] = ch;
      mcol++;
      if (mcol == 80) begin
        mcol = 0;
        next_row();
      end
    end else if (ch == 8'h0A) begin
      mcol = 0;
      next_row();
    end else if (ch == 8'h0D) begin
      mcol = 0;
    end else if (ch == 8'h08 && mcol > 0) begin
      mcol--;
      scr[mrow * 80 + mcol] = 8'h20;
    end
  endfunction

  // Inputs only change just after a rising edge, so at the falling edge they equal
  // what the next rising edge samples: check first, then advance the model one edge.
  initial begin
    int c, r;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("cursor_col", cursor_col, mcol);
        chk("cursor_row", cursor_row, mrow);
        chk("busy", wr_if.busy, (clear_left > 0 && kind_all) ? 1 : 0);
        chk("wr_ready", wr_if.wr_ready, (clear_left == 0 && !wr_if.clr_req) ? 1 : 0);
        chk("rd_active", rd_active, exp_act);
        chk("rd_cell_x", rd_cell_x, exp_cx);
        chk("rd_cell_y", rd_cell_y, exp_cy);
        if (rd_ok) chk("rd_char", rd_char, exp_char);
      end
      c = int'(x) / 8;
      r = int'(y) / 8;
      exp_act  = (c < 80) && (r < 60);
      exp_cx   = 3'(x % 8);
      exp_cy   = 3'(y % 8);
      exp_char = exp_act ? scr[r * 80 + c] : 8'h20;
      rd_ok    = rst_n && (clear_left == 0);
      if (!rst_n) begin
        started = 1'b1;
        mcol = 0;
        mrow = 0;
        clear_left = 4800;
        kind_all = 1'b1;
        exp_act = 1'b0;
        exp_cx = '0;
        exp_cy = '0;
        exp_char = 8'h20;
      end else if (clear_left != 0) begin
        if (!kind_all && wr_if.clr_req) begin
          clear_left = 4800;
          kind_all = 1'b1;
        end else begin
          clear_left--;
          if (clear_left == 0) begin
            if (kind_all) begin
              foreach (scr[i]) scr[i] = 8'h20;
              mcol = 0;
              mrow = 0;
            end else begin
              for (int i = 0; i < 80; i++) scr[i] = 8'h20;
            end
          end
        end
      end else if (wr_if.clr_req) begin
        clear_left = 4800;
        kind_all = 1'b1;
      end else if (wr_if.wr_valid) begin
        apply_char(wr_if.wr_char);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ch);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_char  = ch;
    step();
  endtask

  task automatic release_wr();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic rd_at(input int xv, input int yv);
    x = 10'(xv);
    y = 10'(yv);
    step();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (wr_if.busy === 1'b1 && n < 6000) begin
      step();
      n++;
    end
  endtask

  task automatic count_not_ready(output int n);
    n = 0;
    while (wr_if.wr_ready !== 1'b1 && n < 6000) begin
      step();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] word [4];
    word = '{8'h61, 8'h62, 8'h63, 8'h64};
    wr_if.wr_valid = 1'b0;
    wr_if.wr_char  = 8'h00;
    wr_if.clr_req  = 1'b0;

    // Reset, then the power-on clear.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_rd_char", rd_char, 8'h20);
    chk("reset_rd_active", rd_active, 0);
    count_busy(n);
    chk("init_busy_cycles", n, 4800);
    chk("init_ready", wr_if.wr_ready, 1);

    for (int r = 0; r < 60; r++)
      for (int c = 0; c < 80; c++)
        rd_at(c * 8 + (c % 8), r * 8 + (r % 8));
    rd_at(100, 200);
    chk("init_cell_space", rd_char, 8'h20);

    // "HI" back to back, while reading cell (0,0) during the write.
    x = 0;
    y = 0;
    send(8'h48);
    send(8'h49);
    release_wr();
    chk("hi_col", cursor_col, 2);
    chk("hi_row", cursor_row, 0);
    rd_at(3, 0);
    chk("read_H", rd_char, 8'h48);
    rd_at(12, 5);
    chk("read_I", rd_char, 8'h49);
    chk("read_I_cy", rd_cell_y, 5);

    // CR, then a full line of 'A' wraps to row 1 without a line clear.
    send(8'h0D);
    for (int i = 0; i < 80; i++) send(8'h41);
    release_wr();
    chk("wrap_col", cursor_col, 0);
    chk("wrap_row", cursor_row, 1);
    chk("wrap_ready", wr_if.wr_ready, 1);
    rd_at(632, 0);
    chk("read_A79", rd_char, 8'h41);

    // Backspace at column 0 and mid-line; an unknown control code.
    send(8'h0A);
    send(8'h0A);
    send(8'h08);
    release_wr();
    chk("bs0_col", cursor_col, 0);
    chk("bs0_row", cursor_row, 3);
    foreach (word[i]) send(word[i]);
    send(8'h08);
    send(8'h01);
    release_wr();
    chk("bs_col", cursor_col, 3);
    chk("bs_row", cursor_row, 3);
    rd_at(24, 24);
    chk("bs_cell", rd_char, 8'h20);
    rd_at(16, 24);
    chk("cell_c", rd_char, 8'h63);

    // LF from the last row wraps to row 0 and clears it.
    for (int i = 0; i < 56; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h31 + 8'(i));
    release_wr();
    chk("last_col", cursor_col, 5);
    chk("last_row", cursor_row, 59);
    send(8'h0A);
    release_wr();
    count_not_ready(n);
    chk("line_clear_cycles", n, 80);
    chk("lf_wrap_col", cursor_col, 0);
    chk("lf_wrap_row", cursor_row, 0);
    rd_at(0, 0);
    chk("row0_cleared_c0", rd_char, 8'h20);
    rd_at(632, 7);
    chk("row0_cleared_c79", rd_char, 8'h20);

    // clr_req beats a simultaneous char.
    wr_if.clr_req  = 1'b1;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_char  = 8'h5A;
    #1;
    chk("clr_drops_ready", wr_if.wr_ready, 0);
    step();
    wr_if.clr_req = 1'b0;
    release_wr();
    count_busy(n);
    chk("clr_busy_cycles", n, 4800);
    rd_at(0, 0);
    chk("clr_char_dropped", rd_char, 8'h20);

    // clr_req during a line clear restarts a full clear.
    for (int i = 0; i < 60; i++) send(8'h0A);
    release_wr();
    repeat (10) step();
    chk("in_line_clear_busy", wr_if.busy, 0);
    wr_if.clr_req = 1'b1;
    step();
    wr_if.clr_req = 1'b0;
    count_busy(n);
    chk("abort_busy_cycles", n, 4800);

    // Grid boundaries.
    rd_at(640, 0);
    chk("x640_active", rd_active, 0);
    chk("x640_char", rd_char, 8'h20);
    rd_at(0, 480);
    chk("y480_active", rd_active, 0);
    chk("y480_char", rd_char, 8'h20);
    rd_at(639, 479);
    chk("corner_active", rd_active, 1);
    chk("corner_cx", rd_cell_x, 7);
    chk("corner_cy", rd_cell_y, 7);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
